// File: rtl/usb_line_pkg.sv
// usb_line_pkg: shared line-state encodings, FSM state codes and sampling
// constants for the full-speed receive clock/data recovery slice.
package usb_line_pkg;

  // Line state as {N,P}.
  typedef enum logic [1:0] {
    LS_SE0 = 2'b00,
    LS_J   = 2'b01,
    LS_K   = 2'b10,
    LS_SE1 = 2'b11
  } usb_line_state_t;

  // Receive FSM state codes, kept as plain constants so older tools and
  // existing checkers can match on the raw values.
  typedef logic [1:0] rx_fsm_state_t;
  localparam rx_fsm_state_t ST_IDLE    = 2'd0;
  localparam rx_fsm_state_t ST_ACTIVE  = 2'd1;
  localparam rx_fsm_state_t ST_EOP_SE0 = 2'd2;

  // Phase value at which a bit is taken (mid-bit of a 4-sample bit cell).
  localparam int SAMPLE_PHASE = 2;

  // Bitwise 2-of-3 vote; P and N are voted independently.
  function automatic logic [1:0] majority3(input logic [1:0] a,
                                           input logic [1:0] b,
                                           input logic [1:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/usb_rx_clk_recovery_if.sv
// usb_rx_clk_recovery_if: line inputs and recovered-bit outputs of the
// receive clock recovery stage.
//
// Handshake: rxBitValid is a one-cycle qualifier with no backpressure. The
// stage never waits; rxLineState, eopDetected and rxError are meaningful only
// in a cycle where rxBitValid is high. rxActive and usbResetDetected are
// levels and are valid every cycle. dbgState exposes the receive FSM.
interface usb_rx_clk_recovery_if;
  import usb_line_pkg::*;

  logic          rxEnable;
  logic          dataInP;
  logic          dataInN;
  logic          rxBitValid;
  logic [1:0]    rxLineState;
  logic          rxActive;
  logic          eopDetected;
  logic          rxError;
  logic          usbResetDetected;
  rx_fsm_state_t dbgState;

  // Line side: drives the pin levels and the receive enable.
  modport master (
    output rxEnable, dataInP, dataInN,
    input  rxBitValid, rxLineState, rxActive, eopDetected, rxError,
           usbResetDetected, dbgState
  );

  // Recovery stage side.
  modport slave (
    input  rxEnable, dataInP, dataInN,
    output rxBitValid, rxLineState, rxActive, eopDetected, rxError,
           usbResetDetected, dbgState
  );
endinterface

// File: rtl/usb_rx_glitch_filter.sv
// usb_rx_glitch_filter: 3-sample majority vote on the D+/D- levels, used only
// when USB_RX_GLITCH_FILTER_EN is defined. A single-cycle glitch never wins
// the vote; a real transition reaches the output two cycles after it arrives.
module usb_rx_glitch_filter
  import usb_line_pkg::*;
(
  input  logic       clk48,
  input  logic       rst,
  input  logic [1:0] lineRaw,
  output logic [1:0] lineFiltered
);

  logic [1:0] hist1;
  logic [1:0] hist2;
  logic [1:0] hist3;

  // Three-deep history of the raw line, reset to idle J.
  always_ff @(posedge clk48) begin
    if (rst) begin
      hist1 <= LS_J;
      hist2 <= LS_J;
      hist3 <= LS_J;
    end else begin
      hist1 <= lineRaw;
      hist2 <= hist1;
      hist3 <= hist2;
    end
  end

  assign lineFiltered = majority3(hist1, hist2, hist3);

endmodule

// File: rtl/usb_rx_clk_recovery.sv
// usb_rx_clk_recovery: 4x oversampled full-speed receive clock/data recovery.
// Realigns a 2-bit phase on every line transition, emits one mid-bit sample
// per bit time and tracks packet activity, EOP, SE1 errors and bus reset.
// Optional: define USB_RX_GLITCH_FILTER_EN to put a 3-sample majority filter
// in front of the line register (adds 2 cycles of latency).
module usb_rx_clk_recovery
  import usb_line_pkg::*;
#(
  parameter int RESET_BITS = 30
) (
  input logic clk48,
  input logic rst,
  usb_rx_clk_recovery_if.slave bus
);

  localparam int               CNT_W      = $clog2(RESET_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(RESET_BITS);
  // The strobe register is loaded on the edge where phase steps onto
  // SAMPLE_PHASE, so the strobe and phase == SAMPLE_PHASE share a cycle.
  localparam logic [1:0]       SAMPLE_PRE = 2'(SAMPLE_PHASE - 1);

  logic [1:0]       lineIn;
  logic [1:0]       lineReg;
  logic [1:0]       phase;
  logic             transition;
  logic             samplePoint;
  usb_line_state_t  sampleState;

  rx_fsm_state_t    state;
  rx_fsm_state_t    stateNext;
  logic [CNT_W-1:0] se0Count;
  logic [CNT_W-1:0] se0CountNext;
  logic             activeNext;
  logic             eopNext;
  logic             errNext;
  logic             resetNext;

`ifdef USB_RX_GLITCH_FILTER_EN
  usb_rx_glitch_filter uGlitchFilter (
    .clk48        (clk48),
    .rst          (rst),
    .lineRaw      ({bus.dataInN, bus.dataInP}),
    .lineFiltered (lineIn)
  );
`else
  assign lineIn = {bus.dataInN, bus.dataInP};
`endif

  // A transition always wins over a sample point: phase reloads, no strobe.
  assign transition  = (lineIn != lineReg);
  assign samplePoint = bus.rxEnable && !transition && (phase == SAMPLE_PRE);
  assign sampleState = usb_line_state_t'(lineReg);
  assign bus.dbgState = state;

  // Line tracking and phase alignment; the line keeps tracking while
  // reception is disabled so it resumes in phase.
  always_ff @(posedge clk48) begin
    if (rst) begin
      lineReg <= LS_J;
      phase   <= '0;
    end else begin
      lineReg <= lineIn;
      if (!bus.rxEnable || transition) begin
        phase <= '0;
      end else begin
        phase <= phase + 2'd1;
      end
    end
  end

  // Packet FSM, SE0 run counter and bus-reset decision for one bit sample.
  always_comb begin
    stateNext    = state;
    se0CountNext = se0Count;
    activeNext   = bus.rxActive;
    eopNext      = 1'b0;
    errNext      = 1'b0;
    resetNext    = bus.usbResetDetected;
    if (samplePoint) begin
      if (sampleState == LS_SE0) begin
        se0CountNext = (se0Count == CNT_MAX) ? se0Count : se0Count + 1'b1;
      end else begin
        se0CountNext = '0;
      end
      resetNext = (se0CountNext == CNT_MAX);

      case (state)
        ST_IDLE: begin
          case (sampleState)
            LS_K:   begin
              stateNext  = ST_ACTIVE;
              activeNext = 1'b1;
            end
            LS_SE1: errNext = 1'b1;
            default: ;
          endcase
        end
        ST_ACTIVE: begin
          case (sampleState)
            LS_SE0: stateNext = ST_EOP_SE0;
            LS_SE1: begin
              errNext    = 1'b1;
              stateNext  = ST_IDLE;
              activeNext = 1'b0;
            end
            default: ;
          endcase
        end
        ST_EOP_SE0: begin
          case (sampleState)
            LS_J: begin
              eopNext    = 1'b1;
              stateNext  = ST_IDLE;
              activeNext = 1'b0;
            end
            LS_K: begin
              errNext   = 1'b1;
              stateNext = ST_ACTIVE;
            end
            LS_SE1: begin
              errNext    = 1'b1;
              stateNext  = ST_IDLE;
              activeNext = 1'b0;
            end
            default: ;
          endcase
        end
        default: begin
          stateNext  = ST_IDLE;
          activeNext = 1'b0;
        end
      endcase

      // A bus reset abandons any packet so its end never looks like an EOP.
      if (resetNext) begin
        stateNext  = ST_IDLE;
        activeNext = 1'b0;
      end
    end
  end

  // Registered outputs; reset and disabled reception both force idle.
  always_ff @(posedge clk48) begin
    if (rst || !bus.rxEnable) begin
      state                <= ST_IDLE;
      se0Count             <= '0;
      bus.rxBitValid       <= 1'b0;
      bus.rxLineState      <= LS_J;
      bus.rxActive         <= 1'b0;
      bus.eopDetected      <= 1'b0;
      bus.rxError          <= 1'b0;
      bus.usbResetDetected <= 1'b0;
    end else begin
      state                <= stateNext;
      se0Count             <= se0CountNext;
      bus.rxBitValid       <= samplePoint;
      if (samplePoint) begin
        bus.rxLineState    <= lineReg;
      end
      bus.rxActive         <= activeNext;
      bus.eopDetected      <= eopNext;
      bus.rxError          <= errNext;
      bus.usbResetDetected <= resetNext;
    end
  end

endmodule
